imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded at reset.
REQ-002 SHALL have parameter BUF_DEPTH, fixed value 2, instruction buffer entries.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  begin/resume fetching.
REQ-006 SHALL have port halt_req  input  1  stop issuing new fetches.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken, flush and reload PC.
REQ-008 SHALL have port redirect_pc  input  32  new fetch address.
REQ-009 SHALL have port pc_addr  output  32  address to imem, equal to current PC register.
REQ-010 SHALL have port instr  input  32  imem read data, combinational from pc_addr, same cycle.
REQ-011 SHALL have port if_valid  output  1  buffer head valid toward decode.
REQ-012 SHALL have port if_instr  output  32  instruction at buffer head.
REQ-013 SHALL have port if_pc  output  32  PC of buffer head.
REQ-014 SHALL have port id_ready  input  1  decode accepts head this cycle.
REQ-015 SHALL have port misalign_err  output  1  one-cycle pulse on misaligned redirect.
REQ-016 SHALL have port running  output  1  high when FSM in RUN.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HALT, encoded in 2 bits.
REQ-018 SHALL transition IDLE->RUN and HALT->RUN on start sampled high.
REQ-019 SHALL transition RUN->HALT on halt_req; halt_req and start both high in RUN -> HALT (halt wins).
REQ-020 SHALL fetch only in RUN: fetch occurs when buffer count < 2, or count == 2 with a pop the same cycle.
REQ-021 SHALL on fetch write {pc_addr, instr} at buffer tail and set PC <= PC + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0, no flag).
REQ-022 SHALL, with buffer full and no pop, hold PC and buffer unchanged (stall).
REQ-023 SHALL drive if_valid = (count != 0) AND NOT redirect_valid; if_instr/if_pc from head entry.
REQ-024 SHALL pop head when if_valid && id_ready; pop and fetch in same cycle keep count unchanged.
REQ-025 SHALL in HALT stop fetching but continue draining buffer to decode.
REQ-026 SHALL on redirect_valid (any state): clear buffer (count = 0), PC <= {redirect_pc[31:2], 2'b00}, no fetch and no pop that cycle; redirect overrides fetch, pop and stall.
REQ-027 SHALL pulse misalign_err high for exactly the cycle after a redirect with redirect_pc[1:0] != 0.
REQ-028 SHALL, on redirect_valid and start in IDLE the same cycle, load redirect PC and enter RUN; first fetch at redirected PC next cycle.
REQ-029 SHALL give first-fetch latency: start sampled at edge N -> RUN; fetch of RESET_PC during cycle N+1; if_valid high after edge N+1.
REQ-030 SHALL preserve program order: if_pc sequence of popped entries strictly PC, PC+4, ... between redirects.
REQ-031 SHALL drive running = 1 only in RUN.

Reset
REQ-032 SHALL on rst_n low at a rising edge: state IDLE, PC = RESET_PC, count = 0, head/tail pointers 0, misalign_err 0.
REQ-033 SHALL keep outputs after reset: pc_addr = RESET_PC, if_valid 0, if_instr 0, if_pc 0, running 0.
REQ-034 SHALL give reset priority over start, halt_req, redirect_valid; reset mid-fetch discards buffer contents.

Verification
REQ-035 Start with id_ready=1, imem returns addr-based data -> pc_addr 0,4,8,...; if_valid from cycle 2, one instruction per cycle, if_pc tracks.
REQ-036 id_ready=0 for 5 cycles in RUN -> count reaches 2, pc_addr holds at 8, if_pc stays 0; release -> 0,4,8 delivered in order, no loss or duplicate.
REQ-037 Redirect to 32'h0000_0100 with buffer full -> if_valid 0 that cycle, next fetch at 0x100, first if_pc 0x100, stale 4/8 never popped.
REQ-038 Redirect to 32'h0000_0103 -> pc_addr 0x100, misalign_err one-cycle pulse.
REQ-039 halt_req with 2 buffered -> no new fetch, both entries drain, if_valid 0, running 0; start -> fetch resumes at held PC.
REQ-040 RESET_PC = 32'hFFFF_FFF8, start -> pc_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; rst_n low mid-run -> IDLE, if_valid 0 next cycle.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// +--------------------------------------------------------------------------+
// | imem_fetch_ctrl: PC sequencer feeding a 2-entry instruction buffer.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_addr,
  input  logic [31:0] instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        misalign_err,
  output logic        running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_instr [BUF_DEPTH];
  logic [31:0] buf_pc    [BUF_DEPTH];
  logic        head;
  logic        tail;
  logic [1:0]  count;

  logic        full;
  logic        pop;
  logic        fetch;

  assign full     = (count == 2'(BUF_DEPTH));
  assign if_valid = (count != 2'd0) && !redirect_valid;
  assign pop      = if_valid && id_ready;
  // A full buffer may still accept a fetch when the head leaves this cycle.
  assign fetch    = (state == RUN) && !redirect_valid && (!full || pop);

  assign pc_addr  = pc;
  assign if_instr = buf_instr[head];
  assign if_pc    = buf_pc[head];
  assign running  = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      head         <= 1'b0;
      tail         <= 1'b0;
      count        <= 2'd0;
      misalign_err <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr[i] <= 32'd0;
        buf_pc[i]    <= 32'd0;
      end
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);

      case (state)
        IDLE:    if (start)    state <= RUN;
        RUN:     if (halt_req) state <= HALT;
        HALT:    if (start)    state <= RUN;
        default:               state <= IDLE;
      endcase

      if (redirect_valid) begin
        // Flush wins over any fetch, pop or stall in the same cycle.
        pc    <= {redirect_pc[31:2], 2'b00};
        head  <= 1'b0;
        tail  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (fetch) begin
          buf_instr[tail] <= instr;
          buf_pc[tail]    <= pc;
          tail            <= tail + 1'b1;
          pc              <= pc + 32'd4;
        end
        if (pop) begin
          head <= head + 1'b1;
        end
        case ({fetch, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_imem_fetch_ctrl;

  localparam logic [31:0] KEY = 32'h5A5A_C3C3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, halt_req, redirect_valid, id_ready;
  logic [31:0] redirect_pc;
  logic [31:0] pc_addr, instr, if_instr, if_pc;
  logic        if_valid, misalign_err, running;
  logic [31:0] pc_addr1, instr1, if_instr1, if_pc1;
  logic        if_valid1, misalign_err1, running1;

  always #5 clk = ~clk;

  // Instruction memory: data is a fixed function of the address.
  assign instr  = pc_addr  ^ KEY;
  assign instr1 = pc_addr1 ^ KEY;

  imem_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_addr(pc_addr), .instr(instr), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .misalign_err(misalign_err), .running(running)
  );

  imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_addr(pc_addr1), .instr(instr1), .if_valid(if_valid1),
    .if_instr(if_instr1), .if_pc(if_pc1), .id_ready(id_ready),
    .misalign_err(misalign_err1), .running(running1)
  );

  int checks = 0;
  int passed = 0;

  // Reference model for the default-parameter instance.
  logic [63:0] mq [$];
  logic [31:0] m_pc  = 32'd0;
  int          m_st  = M_IDLE;
  logic        m_mis = 1'b0;

  task automatic model_edge();
    bit vld, pop, fetch;
    if (!rst_n) begin
      m_st = M_IDLE; m_pc = 32'd0; mq.delete(); m_mis = 1'b0;
      return;
    end
    vld   = (mq.size() != 0) && !redirect_valid;
    pop   = vld && id_ready;
    fetch = (m_st == M_RUN) && !redirect_valid && ((mq.size() < 2) || pop);
    m_mis = redirect_valid && (redirect_pc % 4 != 0);
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc & ~32'd3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (fetch) begin
        mq.push_back({m_pc, m_pc ^ KEY});
        m_pc = m_pc + 32'd4;
      end
    end
    if (m_st == M_IDLE && start) m_st = M_RUN;
    else if (m_st == M_RUN && halt_req) m_st = M_HALT;
    else if (m_st == M_HALT && start) m_st = M_RUN;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; halt_req = 1'b0; redirect_valid = 1'b1;
    redirect_pc = 32'h40; id_ready = 1'b1;
    #1; step();
    rst_n = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    #1;
    checks++;
    if ({pc_addr, if_valid, if_instr, if_pc, running, misalign_err} !== {32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0})
      $display("FAIL reset_outputs: got pc=%h v=%b ins=%h ipc=%h run=%b mis=%b expected 0/0/0/0/0/0",
               pc_addr, if_valid, if_instr, if_pc, running, misalign_err);
    else passed++;
    checks++;
    if (pc_addr1 !== 32'hFFFF_FFF8) $display("FAIL reset_pc_param: got %h expected FFFFFFF8", pc_addr1);
    else passed++;
  endtask

  task automatic test_stream();
    start = 1'b1; id_ready = 1'b1;
    #1; step();
    start = 1'b0;
    #1;
    checks++;
    if ({pc_addr, if_valid, running} !== {32'd0, 1'b0, 1'b1})
      $display("FAIL first_fetch: got pc=%h v=%b run=%b expected 0/0/1", pc_addr, if_valid, running);
    else passed++;
    step();
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if ({if_valid, if_pc, if_instr, pc_addr} !== {1'b1, 32'(4*i), 32'(4*i) ^ KEY, 32'(4*(i+1))})
        $display("FAIL stream_%0d: got v=%b ipc=%h ins=%h pc=%h expected ipc=%h pc=%h",
                 i, if_valid, if_pc, if_instr, pc_addr, 32'(4*i), 32'(4*(i+1)));
      else passed++;
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    rst_n = 1'b0; id_ready = 1'b0;
    #1; step();
    rst_n = 1'b1; start = 1'b1;
    #1; step();
    start = 1'b0;
    repeat (5) step();
    #1;
    checks++;
    if ({pc_addr, if_pc, if_valid} !== {32'd8, 32'd0, 1'b1})
      $display("FAIL stall_hold: got pc=%h ipc=%h v=%b expected 8/0/1", pc_addr, if_pc, if_valid);
    else passed++;
    id_ready = 1'b1;
    exp_pc = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({if_valid, if_pc} !== {1'b1, exp_pc})
        $display("FAIL stall_drain_%0d: got v=%b ipc=%h expected 1/%h", i, if_valid, if_pc, exp_pc);
      else passed++;
      exp_pc = exp_pc + 32'd4;
      step();
    end
  endtask

  task automatic test_redirect();
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    checks++;
    if (if_valid !== 1'b0) $display("FAIL redirect_valid_mask: got %b expected 0", if_valid);
    else passed++;
    step();
    redirect_valid = 1'b0; id_ready = 1'b1;
    #1;
    checks++;
    if ({pc_addr, if_valid} !== {32'h100, 1'b0})
      $display("FAIL redirect_pc: got pc=%h v=%b expected 100/0", pc_addr, if_valid);
    else passed++;
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({if_valid, if_pc} !== {1'b1, 32'h100 + 32'(4*i)})
        $display("FAIL redirect_pop_%0d: got v=%b ipc=%h expected 1/%h", i, if_valid, if_pc, 32'h100 + 32'(4*i));
      else passed++;
      step();
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1; step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({pc_addr, misalign_err, if_valid} !== {32'h100, 1'b1, 1'b0})
      $display("FAIL misalign_pulse: got pc=%h mis=%b v=%b expected 100/1/0", pc_addr, misalign_err, if_valid);
    else passed++;
    step();
    #1;
    checks++;
    if ({misalign_err, if_valid, if_pc} !== {1'b0, 1'b1, 32'h100})
      $display("FAIL misalign_clear: got mis=%b v=%b ipc=%h expected 0/1/100", misalign_err, if_valid, if_pc);
    else passed++;
    step();
  endtask

  task automatic test_halt();
    id_ready = 1'b0;
    #1; step(); step();
    halt_req = 1'b1;
    #1; step();
    halt_req = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({running, pc_addr, if_valid, if_pc} !== {1'b0, 32'h10C, 1'b1, 32'h104 + 32'(4*i)})
        $display("FAIL halt_drain_%0d: got run=%b pc=%h v=%b ipc=%h expected 0/10c/1/%h",
                 i, running, pc_addr, if_valid, if_pc, 32'h104 + 32'(4*i));
      else passed++;
      step();
    end
    #1;
    checks++;
    if ({running, pc_addr, if_valid} !== {1'b0, 32'h10C, 1'b0})
      $display("FAIL halt_empty: got run=%b pc=%h v=%b expected 0/10c/0", running, pc_addr, if_valid);
    else passed++;
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    checks++;
    if ({running, pc_addr} !== {1'b1, 32'h10C})
      $display("FAIL halt_resume: got run=%b pc=%h expected 1/10c", running, pc_addr);
    else passed++;
    step();
    #1;
    checks++;
    if ({if_valid, if_pc, pc_addr} !== {1'b1, 32'h10C, 32'h110})
      $display("FAIL halt_refetch: got v=%b ipc=%h pc=%h expected 1/10c/110", if_valid, if_pc, pc_addr);
    else passed++;
    step();
  endtask

  task automatic test_random();
    logic [34:0] obs, exp;
    for (int i = 0; i < 400; i++) begin
      rst_n          = ($urandom % 64) != 0;
      start          = ($urandom % 6) == 0;
      halt_req       = ($urandom % 10) == 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = $urandom;
      id_ready       = ($urandom % 4) != 0;
      #1;
      obs = {pc_addr, if_valid, running, misalign_err};
      exp = {m_pc, (mq.size() != 0) && !redirect_valid, m_st == M_RUN, m_mis};
      checks++;
      if (obs !== exp) $display("FAIL rand_ctrl_%0d: got %h expected %h", i, obs, exp);
      else passed++;
      if (mq.size() != 0) begin
        checks++;
        if ({if_pc, if_instr} !== mq[0])
          $display("FAIL rand_head_%0d: got %h expected %h", i, {if_pc, if_instr}, mq[0]);
        else passed++;
      end
      step();
    end
    rst_n = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    rst_n = 1'b0;
    #1; step();
    rst_n = 1'b1; start = 1'b1;
    #1; step();
    start = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pc_addr1 !== exp_pc) $display("FAIL wrap_pc_%0d: got %h expected %h", i, pc_addr1, exp_pc);
      else passed++;
      exp_pc = exp_pc + 32'd4;
      step();
    end
    rst_n = 1'b0;
    #1; step();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({if_valid1, running1, pc_addr1} !== {1'b0, 1'b0, 32'hFFFF_FFF8})
      $display("FAIL wrap_midrun_reset: got v=%b run=%b pc=%h expected 0/0/fffffff8",
               if_valid1, running1, pc_addr1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misalign();
    test_halt();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
